// File: rtl/coco_timer_if.sv
// Bridge-side bus bundle for the coco_timer device: write port, address, read data and interrupt.
interface coco_timer_if;
   logic [31:0] DEV_WD;
   logic        DEV0_WE;
   logic [31:0] DEV_Addr;
   logic [31:0] DEV0_RD;
   logic        intrp0;

   modport slave (
      input  DEV_WD,
      input  DEV0_WE,
      input  DEV_Addr,
      output DEV0_RD,
      output intrp0
   );

   modport master (
      output DEV_WD,
      output DEV0_WE,
      output DEV_Addr,
      input  DEV0_RD,
      input  intrp0
   );
endinterface

// File: rtl/coco_timer.sv
// Memory-mapped down-counting timer (device 0): CTRL/PRESET/COUNT registers,
// one-shot or auto-reload, interrupt raised when COUNT reaches zero.
module coco_timer #(
   parameter logic [31:0] ADDR_CTRL   = 32'h7f00,
   parameter logic [31:0] ADDR_PRESET = 32'h7f04,
   parameter logic [31:0] ADDR_COUNT  = 32'h7f08
) (
   input logic         clk,
   input logic         reset,
   coco_timer_if.slave bus
);

   localparam logic [1:0] OFF_CTRL   = ADDR_CTRL[3:2];
   localparam logic [1:0] OFF_PRESET = ADDR_PRESET[3:2];
   localparam logic [1:0] OFF_COUNT  = ADDR_COUNT[3:2];

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

   state_t      r_state;
   logic [3:0]  r_ctrl;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic        r_irq;

   logic        w_wr_ctrl;
   logic        w_wr_preset;
   logic        w_auto;
   logic [31:0] w_rd;

   assign w_wr_ctrl   = bus.DEV0_WE && (bus.DEV_Addr[3:2] == OFF_CTRL);
   assign w_wr_preset = bus.DEV0_WE && (bus.DEV_Addr[3:2] == OFF_PRESET);
   // Mode 1x behaves like auto-reload
   assign w_auto      = |r_ctrl[2:1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_ctrl   <= 4'd0;
         r_preset <= 32'd0;
         r_count  <= 32'd0;
         r_irq    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_ctrl[0]) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_count <= r_preset;
               r_state <= S_CNT;
            end
            S_CNT: begin
               if (!r_ctrl[0]) begin
                  r_state <= S_IDLE;
               end else if (r_count > 32'd1) begin
                  r_count <= r_count - 32'd1;
               end else begin
                  r_count <= 32'd0;
                  r_irq   <= 1'b1;
                  r_state <= S_INT;
               end
            end
            S_INT: begin
               if (w_auto) r_irq <= 1'b0;
               else        r_ctrl[0] <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // Bus writes come last so a CPU CTRL write overrides any FSM update
         if (w_wr_ctrl) begin
            r_ctrl <= bus.DEV_WD[3:0];
            r_irq  <= 1'b0;
         end
         if (w_wr_preset) r_preset <= bus.DEV_WD;
      end
   end

   always_comb begin
      w_rd = 32'd0;
      case (bus.DEV_Addr[3:2])
         OFF_CTRL:   w_rd = {28'd0, r_ctrl};
         OFF_PRESET: w_rd = r_preset;
         OFF_COUNT:  w_rd = r_count;
         default:    w_rd = 32'd0;
      endcase
   end

   assign bus.DEV0_RD = w_rd;
   assign bus.intrp0  = r_irq & r_ctrl[3];

endmodule

// File: tb/tb_coco_timer.sv
// Directed self-checking bench for coco_timer; inputs change and outputs are sampled on the falling edge.
module tb_coco_timer;

   localparam logic [31:0] A_CTRL   = 32'h7f00;
   localparam logic [31:0] A_PRESET = 32'h7f04;
   localparam logic [31:0] A_COUNT  = 32'h7f08;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   coco_timer_if bus ();

   coco_timer #(
      .ADDR_CTRL   (A_CTRL),
      .ADDR_PRESET (A_PRESET),
      .ADDR_COUNT  (A_COUNT)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      bus.DEV_Addr = addr;
      #1;
      chk(tag, bus.DEV0_RD, exp);
   endtask

   // Drive a write across exactly one rising edge; returns on the falling edge after it
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.DEV_Addr = addr;
      bus.DEV_WD   = data;
      bus.DEV0_WE  = 1'b1;
      @(negedge clk);
      bus.DEV0_WE  = 1'b0;
      bus.DEV_WD   = 32'd0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_chk        = 0;
      n_err        = 0;
      reset        = 1'b1;
      bus.DEV_WD   = 32'd0;
      bus.DEV0_WE  = 1'b0;
      bus.DEV_Addr = A_CTRL;
      tick(2);
      reset = 1'b0;
      tick(1);

      chk_rd("rst_ctrl", A_CTRL, 32'd0);
      chk_rd("rst_preset", A_PRESET, 32'd0);
      chk_rd("rst_count", A_COUNT, 32'd0);
      chk("rst_intrp", {31'd0, bus.intrp0}, 32'd0);

      wr(A_PRESET, 32'd7);
      chk_rd("pre_preset", A_PRESET, 32'd7);
      chk_rd("pre_ctrl", A_CTRL, 32'd0);
      chk_rd("pre_count", A_COUNT, 32'd0);
      tick(20);
      chk("pre_intrp", {31'd0, bus.intrp0}, 32'd0);
      chk_rd("pre_count_idle", A_COUNT, 32'd0);

      // One-shot, PRESET=7
      wr(A_CTRL, 32'h9);
      tick(2);
      chk_rd("os_load", A_COUNT, 32'd7);
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         chk_rd("os_count", A_COUNT, 32'd7 - 32'(k));
         chk("os_intrp_lo", {31'd0, bus.intrp0}, 32'd0);
      end
      tick(1);
      chk_rd("os_zero", A_COUNT, 32'd0);
      chk("os_intrp_hi", {31'd0, bus.intrp0}, 32'd1);
      tick(1);
      chk_rd("os_en_clr", A_CTRL, 32'd8);
      chk("os_intrp_hold", {31'd0, bus.intrp0}, 32'd1);
      tick(3);
      chk("os_intrp_hold2", {31'd0, bus.intrp0}, 32'd1);
      chk_rd("os_count_stay", A_COUNT, 32'd0);
      wr(A_CTRL, 32'h0);
      chk("os_intrp_clr", {31'd0, bus.intrp0}, 32'd0);

      // Auto-reload, PRESET=3: period of 6 cycles, one-cycle pulse
      wr(A_PRESET, 32'd3);
      wr(A_CTRL, 32'hB);
      for (int k = 1; k <= 18; k++) begin
         tick(1);
         chk("ar_intrp", {31'd0, bus.intrp0}, (k % 6 == 5) ? 32'd1 : 32'd0);
         if (k % 6 == 2) chk_rd("ar_reload", A_COUNT, 32'd3);
      end
      wr(A_CTRL, 32'h0);
      tick(3);

      // Masked one-shot, PRESET=2
      wr(A_PRESET, 32'd2);
      wr(A_CTRL, 32'h1);
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         chk("mask_intrp", {31'd0, bus.intrp0}, 32'd0);
         if (k == 3) chk_rd("mask_count", A_COUNT, 32'd1);
      end
      chk_rd("mask_ctrl", A_CTRL, 32'd0);
      chk_rd("mask_count_end", A_COUNT, 32'd0);

      // Disable mid-count, PRESET=100
      wr(A_PRESET, 32'd100);
      wr(A_CTRL, 32'h9);
      tick(10);
      chk_rd("dis_running", A_COUNT, 32'd92);
      wr(A_CTRL, 32'h8);
      tick(5);
      chk_rd("dis_frozen", A_COUNT, 32'd91);
      chk("dis_intrp", {31'd0, bus.intrp0}, 32'd0);
      wr(A_CTRL, 32'h9);
      tick(2);
      chk_rd("dis_reload", A_COUNT, 32'd100);
      chk("dis_intrp2", {31'd0, bus.intrp0}, 32'd0);

      // PRESET=1 interrupts three edges after enable, then async reset mid-cycle
      wr(A_CTRL, 32'h0);
      tick(3);
      wr(A_PRESET, 32'd1);
      wr(A_CTRL, 32'h9);
      tick(1);
      chk("p1_intrp_e1", {31'd0, bus.intrp0}, 32'd0);
      tick(1);
      chk("p1_intrp_e2", {31'd0, bus.intrp0}, 32'd0);
      tick(1);
      chk("p1_intrp_e3", {31'd0, bus.intrp0}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_rst_intrp", {31'd0, bus.intrp0}, 32'd0);
      bus.DEV_Addr = A_CTRL;
      #0.5;
      chk("ar_rst_ctrl", bus.DEV0_RD, 32'd0);
      bus.DEV_Addr = A_PRESET;
      #0.5;
      chk("ar_rst_preset", bus.DEV0_RD, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick(4);
      chk_rd("ar_post_count", A_COUNT, 32'd0);
      chk_rd("ar_post_ctrl", A_CTRL, 32'd0);
      chk("ar_post_intrp", {31'd0, bus.intrp0}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
